// File: rtl/ram_port_pkg.sv
// Shared definitions for the RAM port controller.
// Optional build macro: RAM_PORT_CLEAR_EN (zero-fill sweep of the RAM after reset).
package ram_port_pkg;

    localparam int ADDR_W_DEF    = 6;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_BURST_DEF = 8;
    localparam int LEN_W_DEF     = $clog2(MAX_BURST_DEF);

    // Controller states; INIT is only reachable when RAM_PORT_CLEAR_EN is defined.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RSP  = 3'd3,
        INIT = 3'd4
    } state_t;

endpackage

// File: rtl/ram_port_burst_ctr.sv
// Burst address generator: word address with wrap-around increment plus a
// down-counter of remaining beats. 'last' is high when no beats remain after
// the current one.
module ram_port_burst_ctr
    import ram_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  beats_left_reg;

    // Load start address/length on accept; advance one word per step.
    // The address wraps naturally at 2^ADDR_W; the beat counter saturates at 0
    // so the zero-fill sweep can reuse the address path without disturbing it.
    always_ff @(posedge clk) begin
        if (srst) begin
            addr_reg       <= '0;
            beats_left_reg <= '0;
        end else if (load) begin
            addr_reg       <= load_addr;
            beats_left_reg <= load_len;
        end else if (step) begin
            addr_reg <= addr_reg + ADDR_W'(1);
            if (beats_left_reg != '0) begin
                beats_left_reg <= beats_left_reg - LEN_W'(1);
            end
        end
    end

    assign addr = addr_reg;
    assign last = (beats_left_reg == '0);

endmodule

// File: rtl/ram_port_ctrl.sv
// Initiator-side controller for a single-port word RAM. Accepts single-word
// writes and incrementing read bursts on a valid/ready request channel and
// returns read words on a valid/ready response channel. All MEM_* pins come
// straight from registers, so no request/response input reaches the RAM pins
// combinationally.
// Optional build macro: RAM_PORT_CLEAR_EN -- after reset, sweep zeros into
// every RAM word before accepting requests.
module ram_port_ctrl
    import ram_port_pkg::*;
#(
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int LEN_W     = $clog2(MAX_BURST)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    input  logic [LEN_W-1:0]  REQ_LEN,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_LAST,
    output logic              MEM_E,
    output logic              MEM_W,
    output logic              MEM_R,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_D,
    input  logic [DATA_W-1:0] MEM_Q
);

    state_t            state_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              mem_e_reg;
    logic              mem_w_reg;
    logic              mem_r_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_last_reg;

    logic              init_pending;
    logic              accept;
    logic              ctr_load;
    logic              ctr_step;
    logic [ADDR_W-1:0] ctr_addr;
    logic              ctr_last;

`ifdef RAM_PORT_CLEAR_EN
    logic init_pending_reg;

    // Remember that a zero-fill sweep is owed; set by reset, cleared on entering INIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            init_pending_reg <= 1'b1;
        end else if (state_reg == IDLE) begin
            init_pending_reg <= 1'b0;
        end
    end

    assign init_pending = init_pending_reg;
`else
    assign init_pending = 1'b0;
`endif

    // Requests are only taken in IDLE, never while reset is asserted or a sweep is owed.
    assign REQ_READY = (state_reg == IDLE) && !init_pending && !RST;
    assign accept    = REQ_READY && REQ_VALID;

    // Address counter loads on every accept; steps between burst beats and during the sweep.
    assign ctr_load = accept;
    assign ctr_step = !RST &&
                      (((state_reg == RSP) && RSP_READY && !ctr_last) ||
                       (state_reg == INIT));

    ram_port_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_ctr (
        .clk       (CLK),
        .srst      (RST),
        .load      (ctr_load),
        .load_addr (REQ_ADDR),
        .load_len  (REQ_LEN),
        .step      (ctr_step),
        .addr      (ctr_addr),
        .last      (ctr_last)
    );

    // Main controller FSM; RAM strobes and response fields are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            wdata_reg     <= '0;
            mem_e_reg     <= 1'b0;
            mem_w_reg     <= 1'b0;
            mem_r_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (init_pending) begin
                        // Sweep writes zeros starting from address 0 (counter was reset).
                        state_reg <= INIT;
                        wdata_reg <= '0;
                        mem_e_reg <= 1'b1;
                        mem_w_reg <= 1'b1;
                        mem_r_reg <= 1'b0;
                    end else if (accept) begin
                        wdata_reg <= REQ_WDATA;
                        mem_e_reg <= 1'b1;
                        if (REQ_WE) begin
                            state_reg <= WR;
                            mem_w_reg <= 1'b1;
                            mem_r_reg <= 1'b0;
                        end else begin
                            state_reg <= RD;
                            mem_w_reg <= 1'b0;
                            mem_r_reg <= 1'b1;
                        end
                    end
                end

                WR: begin
                    // RAM stores on this edge; writes produce no response.
                    state_reg <= IDLE;
                    mem_e_reg <= 1'b0;
                    mem_w_reg <= 1'b0;
                end

                RD: begin
                    // Capture the RAM's combinational output on the closing edge.
                    rsp_data_reg  <= MEM_Q;
                    rsp_last_reg  <= ctr_last;
                    rsp_valid_reg <= 1'b1;
                    mem_e_reg     <= 1'b0;
                    mem_r_reg     <= 1'b0;
                    state_reg     <= RSP;
                end

                RSP: begin
                    // Hold the beat (and keep the RAM idle) until the consumer takes it.
                    if (RSP_READY) begin
                        rsp_valid_reg <= 1'b0;
                        if (!ctr_last) begin
                            state_reg <= RD;
                            mem_e_reg <= 1'b1;
                            mem_r_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                INIT: begin
                    // One zero word per cycle; leave once the top address has been written.
                    if (ctr_addr == '1) begin
                        state_reg <= IDLE;
                        mem_e_reg <= 1'b0;
                        mem_w_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    mem_e_reg <= 1'b0;
                    mem_w_reg <= 1'b0;
                    mem_r_reg <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_E     = mem_e_reg;
    assign MEM_W     = mem_w_reg;
    assign MEM_R     = mem_r_reg;
    assign MEM_ADDR  = ctr_addr;
    assign MEM_D     = wdata_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_DATA  = rsp_data_reg;
    assign RSP_LAST  = rsp_last_reg;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Self-checking bench for ram_port_ctrl: a behavioural RAM device on the MEM_*
// pins, an expected-contents array updated whenever the bench issues a write,
// directed scenarios followed by randomized write/read traffic.
module tb_ram_port_ctrl;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [5:0]  REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic [2:0]  REQ_LEN;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [15:0] RSP_DATA;
    logic        RSP_LAST;
    logic        MEM_E;
    logic        MEM_W;
    logic        MEM_R;
    logic [5:0]  MEM_ADDR;
    logic [15:0] MEM_D;
    logic [15:0] MEM_Q;

    logic [15:0] ram     [64];
    logic [15:0] ref_mem [64];

    int checks = 0;
    int errors = 0;

    ram_port_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_LEN   (REQ_LEN),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_LAST  (RSP_LAST),
        .MEM_E     (MEM_E),
        .MEM_W     (MEM_W),
        .MEM_R     (MEM_R),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_D     (MEM_D),
        .MEM_Q     (MEM_Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM device: stores on the rising edge when enabled for write, reads combinationally.
    always @(posedge CLK) begin
        if (MEM_E && MEM_W) ram[MEM_ADDR] <= MEM_D;
    end
    assign MEM_Q = ram[MEM_ADDR];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(REQ_READY), 0);
        check({tag, "_rsp_valid"}, 32'(RSP_VALID), 0);
        check({tag, "_rsp_data"},  32'(RSP_DATA),  0);
        check({tag, "_rsp_last"},  32'(RSP_LAST),  0);
        check({tag, "_mem_ewr"},   32'({MEM_E, MEM_W, MEM_R}), 0);
        check({tag, "_mem_addr"},  32'(MEM_ADDR),  0);
        check({tag, "_mem_d"},     32'(MEM_D),     0);
    endtask

    // Called at a falling edge right after RST has been dropped.
    task automatic post_reset();
`ifdef RAM_PORT_CLEAR_EN
        check("init_ready_lo_pre", 32'(REQ_READY), 0);
        @(negedge CLK);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("init_ewr_%0d", i),  32'({MEM_E, MEM_W, MEM_R}), 32'b110);
            check($sformatf("init_addr_%0d", i), 32'(MEM_ADDR), 32'(i));
            check($sformatf("init_d_%0d", i),    32'(MEM_D), 0);
            check($sformatf("init_ready_%0d", i), 32'(REQ_READY), 0);
            ref_mem[i] = 16'h0000;
            @(negedge CLK);
        end
`else
        @(negedge CLK);
`endif
        check("post_reset_ready", 32'(REQ_READY), 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_reset_quiet_%0d", i), 32'({RSP_VALID, MEM_E, MEM_R}), 0);
            @(negedge CLK);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (REQ_READY !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("req_ready_wait", 32'(REQ_READY), 1);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b1;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        REQ_LEN   = 3'($urandom);
        wait_ready();
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_WE    = 1'($urandom);
        check("wr_ewr",   32'({MEM_E, MEM_W, MEM_R}), 32'b110);
        check("wr_addr",  32'(MEM_ADDR), 32'(a));
        check("wr_data",  32'(MEM_D), 32'(d));
        check("wr_busy",  32'(REQ_READY), 0);
        ref_mem[a] = d;
        @(negedge CLK);
        check("wr_pulse_end", 32'(MEM_W), 0);
        $display("write addr=%0d data=%04h", a, d);
    endtask

    // Read burst; stall0 = cycles RSP_READY stays low on beat 0, max_stall bounds
    // random stalls on later beats, rst_beat >= 0 asserts reset while that beat is presented.
    task automatic do_read(input logic [5:0] a, input logic [2:0] len,
                           input int stall0, input int max_stall, input int rst_beat);
        logic [15:0] held;
        logic [5:0]  ea;
        int          st;
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = a;
        REQ_LEN   = len;
        REQ_WDATA = 16'($urandom);
        wait_ready();
        @(negedge CLK);
        REQ_VALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ea = a + 6'(i);
            check($sformatf("rd_strobe_b%0d", i), 32'({MEM_E, MEM_W, MEM_R}), 32'b101);
            check($sformatf("rd_addr_b%0d", i),   32'(MEM_ADDR), 32'(ea));
            check($sformatf("rd_early_b%0d", i),  32'(RSP_VALID), 0);
            @(negedge CLK);
            check($sformatf("rsp_valid_b%0d", i), 32'(RSP_VALID), 1);
            check($sformatf("rsp_data_b%0d", i),  32'(RSP_DATA), 32'(ref_mem[ea]));
            check($sformatf("rsp_last_b%0d", i),  32'(RSP_LAST), 32'(i == int'(len)));
            check($sformatf("rsp_mem_r_b%0d", i), 32'(MEM_R), 0);
            $display("read beat addr=%0d data=%04h last=%0b", ea, RSP_DATA, RSP_LAST);
            if (i == rst_beat) begin
                RST = 1'b1;
                @(negedge CLK);
                check_all_zero("rst_mid");
                RST = 1'b0;
                post_reset();
                return;
            end
            st   = (i == 0) ? stall0 : int'($urandom_range(max_stall, 0));
            held = RSP_DATA;
            for (int s = 0; s < st; s++) begin
                RSP_READY = 1'b0;
                @(negedge CLK);
                check($sformatf("bp_valid_b%0d_s%0d", i, s), 32'(RSP_VALID), 1);
                check($sformatf("bp_data_b%0d_s%0d", i, s),  32'(RSP_DATA), 32'(held));
                check($sformatf("bp_mem_r_b%0d_s%0d", i, s), 32'(MEM_R), 0);
            end
            RSP_READY = 1'b1;
            @(negedge CLK);
            RSP_READY = 1'b0;
            check($sformatf("rsp_drop_b%0d", i), 32'(RSP_VALID), 0);
        end
        check("rd_done_ready", 32'(REQ_READY), 1);
    endtask

    initial begin
        logic [5:0] ra;
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        REQ_LEN   = '0;
        RSP_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        post_reset();

        // Single write then single-word read back.
        do_write(6'd5, 16'hA5A5);
        do_read(6'd5, 3'd0, 0, 0, -1);

        // Eight-word burst.
        for (int i = 0; i < 8; i++) do_write(6'(10 + i), 16'(16'h0010 + i));
        do_read(6'd10, 3'd7, 0, 0, -1);

        // Address wrap at the top of the RAM.
        do_write(6'd62, 16'd1);
        do_write(6'd63, 16'd2);
        do_write(6'd0,  16'd3);
        do_write(6'd1,  16'd4);
        do_read(6'd62, 3'd3, 0, 0, -1);

        // Backpressure on the first beat.
        do_read(6'd10, 3'd1, 5, 0, -1);

        // Reset while beat 2 of an eight-beat burst is presented.
        do_read(6'd10, 3'd7, 0, 0, 1);

`ifdef RAM_PORT_CLEAR_EN
        do_read(6'd40, 3'd0, 0, 0, -1);
`endif

        // Fill every word, then random traffic against the expected contents.
        for (int i = 0; i < 64; i++) do_write(6'(i), 16'($urandom));
        for (int t = 0; t < 40; t++) begin
            ra = 6'($urandom);
            if ($urandom_range(1, 0) == 1) do_write(ra, 16'($urandom));
            else do_read(ra, 3'($urandom), int'($urandom_range(2, 0)), 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
Initiator-side controller that drives the 64x16 word RAM's CLK/W/R/E/ADDR/D pins and captures its OUT bus. Sits between the processor's load/store unit and the RAM. Accepts single-word writes and 1–8 word incrementing read bursts on a valid/ready request channel. Returns read data on a valid/ready response channel.

Parameters:
ADDR_W, 6, RAM word-address width; burst addresses wrap modulo 2^ADDR_W.
DATA_W, 16, RAM data width.
MAX_BURST, 8, maximum read burst length; LEN field width = clog2(MAX_BURST).

Ports:
CLK  input  1  single clock; everything changes on the rising edge.
RST  input  1  reset, synchronous, active-high.
REQ_VALID  input  1  request present.
REQ_READY  output  1  controller accepts a request this cycle.
REQ_WE  input  1  1 = write (single word), 0 = read burst.
REQ_ADDR  input  ADDR_W  start word address.
REQ_WDATA  input  DATA_W  write data.
REQ_LEN  input  3  read burst length minus 1; ignored for writes.
RSP_VALID  output  1  read data valid.
RSP_READY  input  1  consumer takes the read data.
RSP_DATA  output  DATA_W  read word.
RSP_LAST  output  1  final beat of a burst.
MEM_E  output  1  RAM enable.
MEM_W  output  1  RAM write strobe.
MEM_R  output  1  RAM read strobe.
MEM_ADDR  output  ADDR_W  RAM address.
MEM_D  output  DATA_W  RAM write data.
MEM_Q  input  DATA_W  RAM OUT bus (combinational from the RAM cells).

Behaviour:
- Reset (RST high at an edge): state IDLE. All outputs 0: REQ_READY, RSP_VALID, RSP_DATA, RSP_LAST, MEM_E/W/R, MEM_ADDR, MEM_D. REQ_READY is forced 0 while RST is high.
- MEM_* outputs are decoded only from registered state and registers. There is no combinational path from any REQ_* or RSP_READY input to MEM_*.
- States and transitions:
  - IDLE: REQ_READY=1, MEM_E/W/R=0. On REQ_VALID&REQ_READY, latch addr, wdata, we and len (beats_left=len). Go to WR if we=1, else RD.
  - WR: MEM_E=1, MEM_W=1, MEM_ADDR=addr, MEM_D=wdata. The RAM stores on the closing edge. Then go to IDLE. No response is issued for writes. Request-accept to RAM-write = 1 edge; sustained write rate = 1 per 2 cycles.
  - RD: MEM_E=1, MEM_R=1, MEM_ADDR=addr. On the closing edge, RSP_DATA<=MEM_Q, RSP_LAST<=(beats_left==0), RSP_VALID<=1. Go to RSP.
  - RSP: MEM_E/R=0. RSP_VALID, RSP_DATA and RSP_LAST are held stable until RSP_READY is sampled high. On the handshake, RSP_VALID<=0, then:
    - if beats_left!=0: addr<=(addr+1) mod 64, beats_left--, go to RD;
    - otherwise go to IDLE.
- Read latency: request accept edge k → RSP_VALID high in cycle k+2. Throughput with RSP_READY tied high is 1 beat per 2 cycles.
- Address wrap: a burst starting at 62 with len=3 reads 62, 63, 0, 1.
- Backpressure: RSP_READY low holds RSP indefinitely. MEM_R stays 0 while held, so no re-read occurs.
- Simultaneous events: requests are sampled only in IDLE. A REQ_VALID during WR, RD or RSP is ignored and not stored; the requester holds it until REQ_READY.
- Reset mid-operation: the burst is abandoned and no further RSP beats are produced. If RST rises during WR, the RAM write at that edge still completes, because the RAM has no reset.

Optional Feature:
RAM_PORT_CLEAR_EN — when defined, the first edge with RST low enters INIT.
- INIT writes 0 to addresses 0..63, one word per cycle (MEM_E=1, MEM_W=1, MEM_D=0), then goes to IDLE.
- REQ_READY stays 0 for those 64 cycles.
- RST during INIT restarts the sweep at 0 once RST drops.
When undefined, the controller leaves reset directly to IDLE and RAM contents are undefined (x) until written.

Decomposition:
Package ram_port_pkg holds:
- the state enum (IDLE, WR, RD, RSP, INIT);
- ADDR_W/DATA_W/MAX_BURST defaults and the LEN width constant.

One sub-module is natural: ram_port_burst_ctr. It holds the address register with modulo-64 increment and the beats_left down-counter, with load/step inputs and a last output.

Test Plan:
- Write REQ_ADDR=5, WDATA=16'hA5A5, then read ADDR=5 len=0 → MEM_W pulses 1 cycle at addr 5; RSP_DATA=16'hA5A5, RSP_LAST=1, RSP_VALID 2 cycles after accept.
- Write 16'h0010+i to addr 10..17, then read addr 10 len=7 → 8 beats 16'h0010..16'h0017, RSP_LAST only on beat 8, MEM_ADDR 10..17.
- Wrap: write 62,63,0,1 with 1,2,3,4, then read 62 len=3 → data 1,2,3,4 and MEM_ADDR sequence 62,63,0,1.
- Backpressure: read len=1 with RSP_READY held low 5 cycles on beat 1 → RSP_DATA stable, MEM_R=0 throughout, beat 2 follows only after the handshake.
- Reset mid-burst: assert RST on beat 2 of a len=7 read → next cycle all outputs 0; REQ_READY=1 the cycle after RST drops (macro off); no stray RSP_VALID.
- With RAM_PORT_CLEAR_EN: release reset → 64 consecutive MEM_W cycles at addr 0..63 with MEM_D=0, REQ_READY=0 throughout; then read addr 40 → 16'h0000.
